// File: rtl/enigma_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : enigma_block_sequencer
// Purpose  : Packs a byte stream into 16-byte blocks for the Enigma core,
//            holds the block while the core settles, then streams the result.
// Revision : 1.0  initial release
// ============================================================================
module enigma_block_sequencer #(
  parameter int CORE_LAT = 1,
  parameter bit STEP_EN  = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_load,
  input  logic         cfg_mode,
  input  logic [7:0]   cfg_key,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic         out_valid,
  output logic [7:0]   out_data,
  input  logic         out_ready,
  output logic [127:0] core_a,
  output logic         core_mode,
  output logic [7:0]   core_s,
  input  logic [127:0] core_w,
  output logic         busy,
  output logic [15:0]  blk_cnt
);

  localparam int LAT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam logic [LAT_W-1:0] c_lat_last = LAT_W'(CORE_LAT - 1);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_EVAL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_idx;
  logic [LAT_W-1:0]   r_lat;
  logic [127:0]       r_core_a;
  logic [127:0]       r_buf;
  logic               r_mode;
  logic [7:0]         r_s;
  logic [15:0]        r_blk;

  logic w_accept;
  logic w_cfg;
  logic w_out_hs;
  logic w_fill_done;
  logic w_eval_done;
  logic w_drain_done;

  assign in_ready     = (r_state == ST_FILL) & ~cfg_load;
  assign w_accept     = in_valid & in_ready;
  assign w_cfg        = cfg_load & (r_state == ST_FILL) & (r_idx == 4'd0);
  assign out_valid    = (r_state == ST_DRAIN);
  assign out_data     = out_valid ? r_buf[{r_idx, 3'b000} +: 8] : 8'h00;
  assign w_out_hs     = out_valid & out_ready;
  assign w_fill_done  = w_accept & ((r_idx == 4'd15) | in_last);
  assign w_eval_done  = (r_state == ST_EVAL) & (r_lat == c_lat_last);
  assign w_drain_done = w_out_hs & (r_idx == 4'd15);

  assign core_a    = r_core_a;
  assign core_mode = r_mode;
  assign core_s    = r_s;
  assign busy      = (r_state != ST_FILL);
  assign blk_cnt   = r_blk;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FILL;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_FILL:  if (w_fill_done)  w_state_nxt = ST_EVAL;
      ST_EVAL:  if (w_eval_done)  w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_drain_done) w_state_nxt = ST_FILL;
      default:                    w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx    <= 4'd0;
      r_lat    <= '0;
      r_core_a <= '0;
      r_buf    <= '0;
      r_mode   <= 1'b0;
      r_s      <= 8'h00;
      r_blk    <= 16'd0;
    end else begin
      unique case (r_state)
        ST_FILL: begin
          r_lat <= '0;
          if (w_cfg) begin
            r_mode <= cfg_mode;
            r_s    <= cfg_key;
          end
          if (w_accept) begin
            // A short final byte zero-pads the remainder of the block in the same cycle
            for (int k = 0; k < 16; k++) begin
              if (4'(k) == r_idx)
                r_core_a[8*k +: 8] <= in_data;
              else if ((4'(k) > r_idx) && in_last)
                r_core_a[8*k +: 8] <= 8'h00;
            end
            r_idx <= w_fill_done ? 4'd0 : r_idx + 4'd1;
          end
        end
        ST_EVAL: begin
          r_lat <= r_lat + LAT_W'(1);
          if (w_eval_done) r_buf <= core_w;
        end
        ST_DRAIN: begin
          if (w_out_hs) begin
            if (r_idx == 4'd15) begin
              r_idx    <= 4'd0;
              r_blk    <= r_blk + 16'd1;
              r_core_a <= '0;
              if (STEP_EN) r_s <= r_s + 8'd1;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_enigma_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_enigma_block_sequencer
// Purpose  : Self-checking bench with a stand-in core and a byte-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_enigma_block_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_load;
  logic         cfg_mode;
  logic [7:0]   cfg_key;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_ready;
  logic         out_valid;
  logic [7:0]   out_data;
  logic         out_ready;
  logic [127:0] core_a;
  logic         core_mode;
  logic [7:0]   core_s;
  logic [127:0] core_w;
  logic         busy;
  logic [15:0]  blk_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_key;
  logic       m_mode;
  int         m_blk;
  logic [7:0] plain  [16];
  logic [7:0] cipher [16];

  always #5 clk = ~clk;

  enigma_block_sequencer #(.CORE_LAT(1), .STEP_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_mode(cfg_mode), .cfg_key(cfg_key),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .core_a(core_a), .core_mode(core_mode), .core_s(core_s), .core_w(core_w),
    .busy(busy), .blk_cnt(blk_cnt)
  );

  // Stand-in invertible core: add a per-byte keystream to encrypt, subtract to decrypt
  function automatic logic [7:0] core_byte(input logic [7:0] a, input int k,
                                           input logic mode, input logic [7:0] s);
    logic [7:0] ks;
    ks = s ^ 8'(k * 37 + 11);
    return mode ? (a - ks) : (a + ks);
  endfunction

  function automatic logic [7:0] exp_byte(input logic [7:0] b [16], input int n, input int k,
                                          input logic mode, input logic [7:0] key);
    return core_byte((k < n) ? b[k] : 8'h00, k, mode, key);
  endfunction

  always_comb begin
    core_w = '0;
    for (int k = 0; k < 16; k++)
      core_w[8*k +: 8] = core_byte(core_a[8*k +: 8], k, core_mode, core_s);
  end

  task automatic load_cfg(input logic mode, input logic [7:0] key);
    @(negedge clk);
    cfg_load = 1'b1; cfg_mode = mode; cfg_key = key;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] b [16], input int first, input int n_end,
                            input bit use_last, input int gap_pct, output bit tmo);
    int i;
    int cyc;
    i = first; cyc = 0; tmo = 1'b0;
    while (i < n_end && cyc < 400) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_data  = b[i];
      in_last  = use_last && (i == n_end - 1);
      #1;
      if (in_valid && in_ready) i++;
      cyc++;
    end
    if (i < n_end) tmo = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic collect(input int pattern, input int max_n, output logic [7:0] got [16],
                         output int n, output bit tmo);
    int cyc;
    cyc = 0; n = 0; tmo = 1'b0;
    for (int k = 0; k < 16; k++) got[k] = 8'h00;
    while (n < max_n && cyc < 400) begin
      @(negedge clk);
      case (pattern)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (cyc % 3 == 0);
      endcase
      #1;
      if (out_valid && out_ready) begin got[n] = out_data; n++; end
      cyc++;
    end
    if (n < max_n) tmo = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_load = 1'b1; cfg_mode = 1'b1; cfg_key = 8'hAA;
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; cfg_load = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 8'h00)  begin errors++; $display("FAIL rst_out_data got %02h exp 00", out_data); end
    checks++; if (core_a !== '0)       begin errors++; $display("FAIL rst_core_a got %032h exp 0", core_a); end
    checks++; if (core_mode !== 1'b0)  begin errors++; $display("FAIL rst_core_mode got %b exp 0", core_mode); end
    checks++; if (core_s !== 8'h00)    begin errors++; $display("FAIL rst_core_s got %02h exp 00", core_s); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (blk_cnt !== 16'd0)   begin errors++; $display("FAIL rst_blk_cnt got %0d exp 0", blk_cnt); end
    m_key = 8'h00; m_mode = 1'b0; m_blk = 0;
  endtask

  task automatic test_key_load_stream();
    logic [7:0]   got [16];
    logic [127:0] exp_a;
    int           n;
    bit           tmo;
    @(negedge clk);
    cfg_load = 1'b1; cfg_mode = 1'b0; cfg_key = 8'h0F;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL cfg_blocks_input got %b exp 0", in_ready); end
    @(negedge clk);
    cfg_load = 1'b0; m_key = 8'h0F; m_mode = 1'b0;
    send_bytes(plain, 0, 16, 1'b0, 0, tmo);
    #1;
    checks++; if (tmo) begin errors++; $display("FAIL stream_send_timeout got 1 exp 0"); end
    for (int k = 0; k < 16; k++) exp_a[8*k +: 8] = plain[k];
    checks++; if (core_a !== exp_a)   begin errors++; $display("FAIL stream_core_a got %032h exp %032h", core_a, exp_a); end
    checks++; if (core_s !== 8'h0F)   begin errors++; $display("FAIL stream_core_s got %02h exp 0f", core_s); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL stream_eval_busy got busy=%b in_ready=%b exp 1/0", busy, in_ready); end
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_latency got out_valid=%b exp 1", out_valid); end
    collect(0, 16, got, n, tmo);
    checks++; if (tmo || n != 16) begin errors++; $display("FAIL stream_count got %0d exp 16", n); end
    for (int k = 0; k < 16; k++) begin
      cipher[k] = got[k];
      checks++;
      if (got[k] !== exp_byte(plain, 16, k, 1'b0, 8'h0F)) begin
        errors++; $display("FAIL stream_byte[%0d] got %02h exp %02h", k, got[k], exp_byte(plain, 16, k, 1'b0, 8'h0F));
      end
    end
    m_blk++; m_key = m_key + 8'd1;
    @(negedge clk); out_ready = 1'b0; #1;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL stream_ready_back got %b exp 1", in_ready); end
    checks++; if (core_s !== 8'h10)   begin errors++; $display("FAIL stream_key_step got %02h exp 10", core_s); end
    checks++; if (blk_cnt !== 16'd1)  begin errors++; $display("FAIL stream_blk_cnt got %0d exp 1", blk_cnt); end
    checks++; if (core_a !== '0)      begin errors++; $display("FAIL stream_core_a_clear got %032h exp 0", core_a); end
  endtask

  task automatic test_round_trip();
    logic [7:0] got [16];
    int         n;
    bit         tmo;
    load_cfg(1'b1, 8'h0F);
    m_key = 8'h0F; m_mode = 1'b1;
    send_bytes(cipher, 0, 16, 1'b0, 25, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL rt_send_timeout got 1 exp 0"); end
    collect(1, 16, got, n, tmo);
    checks++; if (tmo || n != 16) begin errors++; $display("FAIL rt_count got %0d exp 16", n); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (got[k] !== plain[k]) begin errors++; $display("FAIL rt_byte[%0d] got %02h exp %02h", k, got[k], plain[k]); end
    end
    m_blk++; m_key = m_key + 8'd1;
    @(negedge clk); out_ready = 1'b0; #1;
    checks++; if (blk_cnt !== 16'(m_blk)) begin errors++; $display("FAIL rt_blk_cnt got %0d exp %0d", blk_cnt, m_blk); end
  endtask

  task automatic test_short_message();
    logic [7:0] b   [16];
    logic [7:0] got [16];
    int         n;
    bit         tmo;
    for (int k = 0; k < 16; k++) b[k] = (k < 5) ? 8'(8'h41 + k) : 8'($urandom);
    send_bytes(b, 0, 5, 1'b1, 30, tmo);
    #1;
    checks++; if (tmo) begin errors++; $display("FAIL short_send_timeout got 1 exp 0"); end
    checks++; if (core_a[127:40] !== '0) begin errors++; $display("FAIL short_pad got %022h exp 0", core_a[127:40]); end
    checks++; if (core_a[39:0] !== 40'h4544434241) begin errors++; $display("FAIL short_data got %010h exp 4544434241", core_a[39:0]); end
    collect(0, 16, got, n, tmo);
    checks++; if (tmo || n != 16) begin errors++; $display("FAIL short_count got %0d exp 16", n); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (got[k] !== exp_byte(b, 5, k, m_mode, m_key)) begin
        errors++; $display("FAIL short_byte[%0d] got %02h exp %02h", k, got[k], exp_byte(b, 5, k, m_mode, m_key));
      end
    end
    m_blk++; m_key = m_key + 8'd1;
    @(negedge clk); out_ready = 1'b1; #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL short_extra_byte got valid=%b ready=%b exp 0/1", out_valid, in_ready); end
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] b   [16];
    logic [7:0] got [16];
    logic [7:0] prev_d;
    bit         prev_stall;
    bit         tmo;
    int         n;
    int         cyc;
    for (int k = 0; k < 16; k++) b[k] = 8'($urandom);
    send_bytes(b, 0, 16, 1'b0, 0, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL bp_send_timeout got 1 exp 0"); end
    n = 0; cyc = 0; prev_stall = 1'b0; prev_d = 8'h00;
    while (n < 16 && cyc < 200) begin
      @(negedge clk);
      out_ready = (cyc % 3 == 0);
      #1;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_d) begin
          errors++; $display("FAIL bp_hold got valid=%b data=%02h exp 1/%02h", out_valid, out_data, prev_d);
        end
      end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
      if (out_valid && out_ready) begin got[n] = out_data; n++; end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      cyc++;
    end
    checks++; if (n != 16) begin errors++; $display("FAIL bp_count got %0d exp 16", n); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (got[k] !== exp_byte(b, 16, k, m_mode, m_key)) begin
        errors++; $display("FAIL bp_byte[%0d] got %02h exp %02h", k, got[k], exp_byte(b, 16, k, m_mode, m_key));
      end
    end
    m_blk++; m_key = m_key + 8'd1;
    @(negedge clk); out_ready = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b exp 1", in_ready); end
  endtask

  task automatic test_key_wrap();
    logic [7:0] b   [16];
    logic [7:0] got [16];
    int         n;
    bit         tmo;
    load_cfg(1'b0, 8'hFF);
    m_key = 8'hFF; m_mode = 1'b0;
    for (int k = 0; k < 16; k++) b[k] = 8'($urandom);
    send_bytes(b, 0, 3, 1'b0, 0, tmo);
    cfg_load = 1'b1; cfg_key = 8'h33; cfg_mode = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL wrap_cfg_ready got %b exp 0", in_ready); end
    @(negedge clk); cfg_load = 1'b0; #1;
    checks++; if (core_s !== 8'hFF || core_mode !== 1'b0) begin errors++; $display("FAIL wrap_cfg_ignored got s=%02h m=%b exp ff/0", core_s, core_mode); end
    send_bytes(b, 3, 16, 1'b0, 20, tmo);
    #1;
    checks++; if (tmo) begin errors++; $display("FAIL wrap_send_timeout got 1 exp 0"); end
    checks++; if (core_s !== 8'hFF) begin errors++; $display("FAIL wrap_key_ff got %02h exp ff", core_s); end
    collect(0, 16, got, n, tmo);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (got[k] !== exp_byte(b, 16, k, 1'b0, 8'hFF)) begin
        errors++; $display("FAIL wrap_byte[%0d] got %02h exp %02h", k, got[k], exp_byte(b, 16, k, 1'b0, 8'hFF));
      end
    end
    m_blk++; m_key = 8'h00;
    @(negedge clk); out_ready = 1'b0; #1;
    checks++; if (core_s !== 8'h00) begin errors++; $display("FAIL wrap_key_00 got %02h exp 00", core_s); end
    for (int k = 0; k < 16; k++) b[k] = 8'($urandom);
    send_bytes(b, 0, 16, 1'b0, 0, tmo);
    collect(1, 16, got, n, tmo);
    checks++; if (tmo || n != 16) begin errors++; $display("FAIL wrap2_count got %0d exp 16", n); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (got[k] !== exp_byte(b, 16, k, 1'b0, 8'h00)) begin
        errors++; $display("FAIL wrap2_byte[%0d] got %02h exp %02h", k, got[k], exp_byte(b, 16, k, 1'b0, 8'h00));
      end
    end
    m_blk++; m_key = 8'h01;
    @(negedge clk); out_ready = 1'b0; #1;
    checks++; if (core_s !== 8'h01) begin errors++; $display("FAIL wrap2_key got %02h exp 01", core_s); end
  endtask

  task automatic test_reset_mid_drain();
    logic [7:0] b   [16];
    logic [7:0] got [16];
    int         n;
    bit         tmo;
    load_cfg(1'b1, 8'h5A);
    for (int k = 0; k < 16; k++) b[k] = 8'($urandom);
    send_bytes(b, 0, 16, 1'b0, 0, tmo);
    collect(0, 7, got, n, tmo);
    checks++; if (n != 7) begin errors++; $display("FAIL rd_partial got %0d exp 7", n); end
    @(negedge clk); rst = 1'b1; out_ready = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rd_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rd_in_ready got %b exp 1", in_ready); end
    checks++; if (core_s !== 8'h00)   begin errors++; $display("FAIL rd_core_s got %02h exp 00", core_s); end
    checks++; if (blk_cnt !== 16'd0)  begin errors++; $display("FAIL rd_blk_cnt got %0d exp 0", blk_cnt); end
    checks++; if (core_a !== '0 || busy !== 1'b0 || core_mode !== 1'b0) begin errors++; $display("FAIL rd_state got busy=%b mode=%b a=%032h exp 0", busy, core_mode, core_a); end
    m_key = 8'h00; m_mode = 1'b0; m_blk = 0;
  endtask

  task automatic test_random();
    logic [7:0] b   [16];
    logic [7:0] got [16];
    int         n;
    int         len;
    bit         last;
    bit         tmo;
    logic       mode;
    logic [7:0] key;
    for (int blk = 0; blk < 12; blk++) begin
      if ($urandom_range(0, 2) == 0) begin
        mode = 1'($urandom); key = 8'($urandom);
        load_cfg(mode, key);
        m_mode = mode; m_key = key;
      end
      len  = $urandom_range(1, 16);
      last = (len < 16) ? 1'b1 : 1'($urandom);
      for (int k = 0; k < 16; k++) b[k] = 8'($urandom);
      send_bytes(b, 0, len, last, $urandom_range(0, 50), tmo);
      #1;
      checks++; if (tmo) begin errors++; $display("FAIL rnd_send_timeout blk %0d", blk); end
      checks++; if (core_s !== m_key || core_mode !== m_mode) begin errors++; $display("FAIL rnd_cfg blk %0d got %02h/%b exp %02h/%b", blk, core_s, core_mode, m_key, m_mode); end
      collect(1, 16, got, n, tmo);
      checks++; if (tmo || n != 16) begin errors++; $display("FAIL rnd_count blk %0d got %0d exp 16", blk, n); end
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (got[k] !== exp_byte(b, len, k, m_mode, m_key)) begin
          errors++; $display("FAIL rnd_byte blk %0d [%0d] got %02h exp %02h", blk, k, got[k], exp_byte(b, len, k, m_mode, m_key));
        end
      end
      m_blk++; m_key = m_key + 8'd1;
      @(negedge clk); out_ready = 1'b0; #1;
      checks++; if (blk_cnt !== 16'(m_blk) || core_s !== m_key) begin errors++; $display("FAIL rnd_post blk %0d got cnt=%0d s=%02h exp %0d/%02h", blk, blk_cnt, core_s, m_blk, m_key); end
    end
  endtask

  initial begin
    plain = '{8'h43, 8'h52, 8'h59, 8'h50, 8'h54, 8'h4F, 8'h47, 8'h52,
              8'h41, 8'h50, 8'h48, 8'h49, 8'h43, 8'h53, 8'h59, 8'h53};
    test_reset();
    test_key_load_stream();
    test_round_trip();
    test_short_message();
    test_backpressure();
    test_key_wrap();
    test_reset_mid_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
